fetch_queue: RTL
================

# fetch_queue

Parametrised instruction fetch queue that replaces the single-entry IF/ID pipeline register between the IF and ID stages of the five-stage MIPS pipeline. It buffers up to DEPTH fetched instruction/PC+1 pairs, lets IF keep fetching while ID is stalled by the hazard unit, and discards all buffered entries when ID resolves a taken branch or jump. Empty-queue output is a MIPS NOP (all zeros), so downstream decode needs no extra valid qualification beyond `id_valid`.

## Interface
- `INS_W`, default 32: instruction width.
- `PC_W`, default 32: PC+1 width.
- `DEPTH`, default 4: entry count; power of two, ≥ 2.
- `CNT_W`, default $clog2(DEPTH)+1: width of the occupancy count.

- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `if_valid`  in  1  IF presents a fetched instruction this cycle.
- `if_ins`  in  INS_W  fetched instruction.
- `if_pc_p1`  in  PC_W  PC+1 of fetched instruction.
- `if_ready`  out  1  queue accepts a push this cycle; IF holds its PC when low (drives Stall_IF).
- `id_valid`  out  1  head entry valid.
- `id_ins`  out  INS_W  head instruction; 0 when empty.
- `id_pc_p1`  out  PC_W  head PC+1; 0 when empty.
- `id_ready`  in  1  ID consumes head this cycle (= not Stall_ID).
- `flush`  in  1  taken branch/jump from ID (ID_PCSrc); discard all entries.
- `count`  out  CNT_W  current occupancy, 0..DEPTH.
- `ovf_err`  out  1  sticky: push attempted while full.

## Operation
- Storage: DEPTH-entry circular buffer, registers for instruction and PC+1; read pointer `rp`, write pointer `wp`, each log2(DEPTH) bits, wrap modulo DEPTH; `count` held separately.
- push = `if_valid & if_ready`; pop = `id_valid & id_ready`.
- `if_ready` = (`count` < DEPTH); combinational from registered count, no dependence on `id_ready` (no pass-through when full).
- `id_valid` = (`count` != 0). `id_ins`/`id_pc_p1` = entry at `rp` when valid, else 0.
- Priority each cycle: reset > flush > push/pop.
- Flush: `rp`←0, `wp`←0, `count`←0; push and pop in same cycle are discarded; `ovf_err` unaffected.
- Push only: write entry at `wp`, `wp`+1, `count`+1.
- Pop only: `rp`+1, `count`−1.
- Push and pop together (count ≥ 1, < DEPTH): write at `wp`, both pointers advance, `count` unchanged.
- Push and pop with count = 0: pop ignored (id_valid low), push proceeds; count → 1.
- Push with count = DEPTH: `if_valid` high while `if_ready` low → no write, `ovf_err`←1 (set only by this condition; cleared only by reset). Simultaneous pop still proceeds.
- `id_ready` high while empty: no effect.

## Timing
- Reset (rst_n = 0 at rising edge): `count`=0, `rp`=`wp`=0, `ovf_err`=0; outputs thereafter `id_valid`=0, `id_ins`=0, `id_pc_p1`=0, `if_ready`=1. Storage contents not cleared (never visible while empty). Reset mid-operation drops all entries identically to flush plus clears `ovf_err`.
- Push latency: entry pushed at edge N is visible at head (if queue was empty) after edge N, i.e. `id_valid`=1 in cycle N+1. No same-cycle bypass.
- Throughput: one push and one pop per cycle sustained; queue steady at constant occupancy.
- Flush at edge N: cycle N+1 shows `id_valid`=0, `count`=0, `if_ready`=1; first post-flush push at edge N+1 visible in cycle N+2.
- `if_ready` falls the cycle after the DEPTH-th entry is written; rises the cycle after a pop from full.
- All outputs are functions of registered state only (no combinational input→output paths), easing the ID-stage hazard logic timing.

## Test plan
- Reset then idle: rst_n low 2 cycles → `count`=0, `id_valid`=0, `id_ins`=0, `if_ready`=1, `ovf_err`=0.
- Fill/drain, DEPTH=4: push ins 0x20010001..0x20010004 (pc_p1 1..4) with `id_ready`=0 → `count`=4, `if_ready`=0; then `id_ready`=1 four cycles → heads appear in order 0x20010001..04, then `id_valid`=0.
- Streaming: push and pop every cycle for 20 cycles starting empty → `count` stays 1 after first cycle, output order equals input order, pointers wrap past 3 → 0 correctly.
- Overflow: fill to 4, hold `if_valid`=1 with `id_ready`=0 → `ovf_err`=1, contents unchanged; assert `id_ready` → `ovf_err` stays 1, head still 0x20010001.
- Flush: 3 entries queued, assert `flush` with `if_valid`=1 and `id_ready`=1 same cycle → next cycle `count`=0, `id_valid`=0, `id_ins`=0; pushed word dropped.
- Reset mid-operation: 2 entries queued, `ovf_err`=1, pull rst_n low one edge → `count`=0, `ovf_err`=0, `if_ready`=1; next push visible one cycle later.

Source files
------------

// File: rtl/fetch_queue.sv
// fetch_queue
//   Instruction fetch queue between the IF and ID stages of the five-stage
//   MIPS pipeline. It replaces the single IF/ID register with a DEPTH-entry
//   circular buffer of {instruction, PC+1} pairs. IF keeps fetching while ID
//   is stalled, and a taken branch/jump from ID discards every buffered entry.
//   When the queue is empty the head reads as a MIPS NOP (all zeros).
//
// Parameters
//   INS_W  instruction width
//   PC_W   PC+1 width
//   DEPTH  entry count (power of two, >= 2)
//   CNT_W  occupancy count width (must hold 0..DEPTH)
//
// Ports
//   clk       in   single clock, rising edge
//   rst_n     in   synchronous active-low reset
//   if_valid  in   IF presents a fetched instruction
//   if_ins    in   fetched instruction
//   if_pc_p1  in   PC+1 of the fetched instruction
//   if_ready  out  queue accepts a push (low = IF must hold its PC)
//   id_valid  out  head entry valid
//   id_ins    out  head instruction, 0 when empty
//   id_pc_p1  out  head PC+1, 0 when empty
//   id_ready  in   ID consumes the head this cycle
//   flush     in   taken branch/jump from ID, drop all entries
//   count     out  current occupancy, 0..DEPTH
//   ovf_err   out  sticky: push attempted while full
module fetch_queue #(
    parameter int INS_W = 32,
    parameter int PC_W  = 32,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             if_valid,
    input  logic [INS_W-1:0] if_ins,
    input  logic [PC_W-1:0]  if_pc_p1,
    output logic             if_ready,
    output logic             id_valid,
    output logic [INS_W-1:0] id_ins,
    output logic [PC_W-1:0]  id_pc_p1,
    input  logic             id_ready,
    input  logic             flush,
    output logic [CNT_W-1:0] count,
    output logic             ovf_err
);

    localparam int PTR_W = $clog2(DEPTH);

    // Pointers wrap modulo DEPTH by natural overflow since DEPTH is a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return p + PTR_W'(1);
    endfunction

    // Storage holds data only; it is never reset because an entry is
    // only visible while the occupancy count says it is live.
    logic [INS_W-1:0] ins_mem [DEPTH];
    logic [PC_W-1:0]  pc_mem  [DEPTH];

    logic [PTR_W-1:0] rp;
    logic [PTR_W-1:0] wp;
    logic [CNT_W-1:0] cnt;
    logic             ovf;

    logic push;
    logic pop;
    logic full;
    logic empty;

    // Handshakes derive from registered occupancy only, so no input reaches
    // an output combinationally. A full queue refuses a push even when ID
    // pops in the same cycle (no pass-through).
    assign full     = (cnt == CNT_W'(DEPTH));
    assign empty    = (cnt == '0);
    assign if_ready = ~full;
    assign id_valid = ~empty;
    assign push     = if_valid & if_ready;
    assign pop      = id_valid & id_ready;

    assign id_ins   = id_valid ? ins_mem[rp] : '0;
    assign id_pc_p1 = id_valid ? pc_mem[rp]  : '0;
    assign count    = cnt;
    assign ovf_err  = ovf;

    // Control state: reset > flush > push/pop.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rp  <= '0;
            wp  <= '0;
            cnt <= '0;
            ovf <= 1'b0;
        end else if (flush) begin
            // Overflow flag survives a flush; only reset clears it.
            rp  <= '0;
            wp  <= '0;
            cnt <= '0;
        end else begin
            if (push) begin
                wp <= ptr_inc(wp);
            end
            if (pop) begin
                rp <= ptr_inc(rp);
            end
            unique case ({push, pop})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
            if (if_valid && full) begin
                ovf <= 1'b1;
            end
        end
    end

    // Entry write; suppressed on reset and flush so a discarded push never lands.
    always_ff @(posedge clk) begin
        if (rst_n && !flush && push) begin
            ins_mem[wp] <= if_ins;
            pc_mem[wp]  <= if_pc_p1;
        end
    end

endmodule
